// File: rtl/time_entry_pkg.sv
// rtl/time_entry_pkg.sv - shared types and constants for the time entry keypad
package time_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam int          MAX_DIGITS = 3;
    localparam logic [11:0] MAX_VALUE  = 12'd999;

    // d2*100 + d1*10 + d0 built from shifts and adds only
    function automatic logic [11:0] bcd_to_bin(input logic [3:0] d2,
                                               input logic [3:0] d1,
                                               input logic [3:0] d0);
        logic [11:0] h, t, o;
        h = 12'(d2);
        t = 12'(d1);
        o = 12'(d0);
        return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + o;
    endfunction

endpackage

// File: rtl/sync_pulse.sv
// rtl/sync_pulse.sv - 2-flop synchronizer plus rising-edge detector, per bit
module sync_pulse #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] s1, s2, s3;
    logic [2:0]       armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            armed <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            armed <= {armed[1:0], 1'b1};
        end
    end

    // Edges stay masked until s3 holds a real sample, so a button held
    // through reset release is seen as already high rather than rising.
    assign pulse = s2 & ~s3 & {WIDTH{armed[2]}};

endmodule

// File: rtl/time_entry.sv
// rtl/time_entry.sv - three-digit decimal keypad entry with backspace, clear and commit
module time_entry
    import time_entry_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  digit_pb,
    input  logic        back_pb,
    input  logic        clear_pb,
    input  logic        enter_pb,
    output logic [11:0] entry_value,
    output logic [1:0]  digit_count,
    output logic [11:0] load_value,
    output logic        load_pulse,
    output logic        full
);

    localparam int         ND       = (NDIG < MAX_DIGITS) ? NDIG : MAX_DIGITS;
    localparam logic [1:0] FULL_CNT = 2'(ND);

    logic [12:0] ev;
    logic [9:0]  dig_ev;
    logic        back_ev, clear_ev, enter_ev;

    sync_pulse #(.WIDTH(13)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({enter_pb, clear_pb, back_pb, digit_pb}),
        .pulse (ev)
    );

    assign dig_ev   = ev[9:0];
    assign back_ev  = ev[10];
    assign clear_ev = ev[11];
    assign enter_ev = ev[12];

    state_t      state, state_n;
    logic [3:0]  d2, d1, d0, d2_n, d1_n, d0_n, sel;
    logic [1:0]  count_n;
    logic [11:0] entry_n, load_n;
    logic        commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            d2          <= '0;
            d1          <= '0;
            d0          <= '0;
            digit_count <= '0;
            entry_value <= '0;
            load_value  <= '0;
        end else begin
            state       <= state_n;
            d2          <= d2_n;
            d1          <= d1_n;
            d0          <= d0_n;
            digit_count <= count_n;
            entry_value <= entry_n;
            load_value  <= load_n;
        end
    end

    always_comb begin
        d2_n    = d2;
        d1_n    = d1;
        d0_n    = d0;
        count_n = digit_count;
        load_n  = load_value;
        commit  = 1'b0;
        sel     = '0;
        for (int k = 9; k >= 0; k--) begin
            if (dig_ev[k]) sel = 4'(k);
        end

        // COMMIT already left the digits cleared, so it behaves as EMPTY here
        if (clear_ev) begin
            d2_n = '0; d1_n = '0; d0_n = '0; count_n = '0;
        end else if (enter_ev && digit_count != 2'd0) begin
            load_n = entry_value;
            commit = 1'b1;
            d2_n = '0; d1_n = '0; d0_n = '0; count_n = '0;
        end else if (back_ev && digit_count != 2'd0) begin
            d0_n    = d1;
            d1_n    = d2;
            d2_n    = '0;
            count_n = digit_count - 2'd1;
        end else if ((|dig_ev) && digit_count < FULL_CNT) begin
            d2_n    = d1;
            d1_n    = d0;
            d0_n    = sel;
            count_n = digit_count + 2'd1;
        end

        if (commit)                 state_n = COMMIT;
        else if (count_n == 2'd0)   state_n = EMPTY;
        else if (count_n == FULL_CNT) state_n = FULL;
        else                        state_n = PARTIAL;

        entry_n = bcd_to_bin(d2_n, d1_n, d0_n);
    end

    assign load_pulse = (state == COMMIT);
    assign full       = (digit_count == FULL_CNT);

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 The block SHALL use parameter NDIG, default 3, meaning the maximum number of decimal digits held (the block is specified only for 3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port digit_pb, input, 10 bits: raw asynchronous push buttons; bit k enters decimal digit k.
REQ-005 The block SHALL have port back_pb, input, 1 bit: raw asynchronous backspace button.
REQ-006 The block SHALL have port clear_pb, input, 1 bit: raw asynchronous clear-entry button.
REQ-007 The block SHALL have port enter_pb, input, 1 bit: raw asynchronous commit button.
REQ-008 The block SHALL have port entry_value, output, 12 bits: binary value of the digits currently held, 0..999.
REQ-009 The block SHALL have port digit_count, output, 2 bits: number of digits held, 0..3.
REQ-010 The block SHALL have port load_value, output, 12 bits: last committed binary value, held until the next commit.
REQ-011 The block SHALL have port load_pulse, output, 1 bit: high for exactly one cycle per commit.
REQ-012 The block SHALL have port full, output, 1 bit: high when digit_count equals 3.

Function
REQ-013 Each of the 13 button inputs SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sync & ~delayed sync); only detected rising edges act.
REQ-014 Latency: if a button is first sampled high at edge N, the resulting output change SHALL be visible after edge N+2; a held button SHALL act once only.
REQ-015 Digits SHALL be stored as three BCD registers d2 (hundreds), d1, d0 (most recent).
REQ-016 Digit edge with count < 3: d2<=d1, d1<=d0, d0<=k, count+1.
REQ-017 Digit edge with count = 3: ignored; no register changes.
REQ-018 If several digit edges occur in one cycle, the lowest index SHALL win and the others are discarded.
REQ-019 Backspace with count > 0: d0<=d1, d1<=d2, d2<=0, count-1; with count = 0 it is ignored.
REQ-020 Clear edge: d2, d1, d0 and count SHALL be set to 0; load_value is unchanged.
REQ-021 Enter with count > 0: load_value SHALL take entry_value, load_pulse SHALL be high the next cycle only, and digits and count SHALL be cleared in the same edge.
REQ-022 Enter with count = 0: ignored; no pulse.
REQ-023 Simultaneous events SHALL be resolved with priority clear > enter > backspace > digit; only the highest-priority event acts.
REQ-024 entry_value SHALL equal d2*100 + d1*10 + d0 computed as shifts and adds, zero-extended to 12 bits and registered, updated in the same edge as the digits.
REQ-025 The FSM SHALL have states EMPTY (count=0), PARTIAL (count 1..2), FULL (count=3) and COMMIT (a 1-cycle state asserting load_pulse, then EMPTY).
REQ-026 An edge arriving while in COMMIT SHALL be processed from EMPTY in that cycle, not lost.

Reset
REQ-027 While reset is high at a clock edge, all synchronizer and edge flops, d2, d1, d0, count, entry_value, load_value and load_pulse SHALL be 0, full SHALL be 0, and the state SHALL be EMPTY.
REQ-028 A button held high through reset release SHALL NOT generate an edge.
REQ-029 Reset asserted mid-entry or during COMMIT SHALL abort with no load_pulse.

Structure
REQ-030 Package time_entry_pkg SHALL hold the state enum, MAX_DIGITS = 3 and MAX_VALUE = 12'd999.
REQ-031 Synchronizer plus edge detector SHALL be one sub-module, sync_pulse, parameterized by width and instantiated once for 13 bits, with synchronous active-high reset.

Verification
REQ-032 The bench SHALL cover: press 4, 2, 7, enter -> entry_value steps 4, 42, 427; load_value = 427; one load_pulse; count returns to 0.
REQ-033 The bench SHALL cover: press 9, 9, 9, 5 -> fourth digit ignored, entry_value = 999, full = 1.
REQ-034 The bench SHALL cover: press 1, 2, back, 5 -> entry_value 1, 12, 1, 15; then back at count 0 leaves 0.
REQ-035 The bench SHALL cover: digit_pb[3] and digit_pb[6] rising in the same cycle -> entry_value = 3; clear and enter in the same cycle -> cleared, no pulse.
REQ-036 The bench SHALL cover: enter with count 0 -> no pulse; digit_pb[5] held for 50 cycles -> exactly one digit entered.
REQ-037 The bench SHALL cover: reset asserted after 8, 1 with enter pending -> all outputs 0, no load_pulse; button held across reset release -> no entry.
